// File: rtl/mult_simd_pipe_if.sv
// -----------------------------------------------------------------------------
// mult_simd_pipe_if
// Handshake and data bundle for the SIMD multiplier pipeline.
//   in_valid / in_ready   : upstream transaction handshake
//   a, b                  : LANES packed INT_SIZE-bit operands, lane 0 leftmost
//   mode                  : bit0 signed, bit1 low-half only
//   out_valid / out_ready : downstream result handshake
//   result                : LANES packed 2*INT_SIZE-bit products, lane 0 leftmost
// Modports:
//   master : the side that issues operands and consumes results
//   slave  : the multiplier pipeline
// -----------------------------------------------------------------------------
interface mult_simd_pipe_if #(
  parameter int INT_SIZE = 16,
  parameter int LANES    = 4
);
  logic                           in_valid;
  logic                           in_ready;
  logic [0:LANES*INT_SIZE-1]      a;
  logic [0:LANES*INT_SIZE-1]      b;
  logic [1:0]                     mode;
  logic                           out_valid;
  logic                           out_ready;
  logic [0:LANES*2*INT_SIZE-1]    result;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mult_simd_pipe.sv
// -----------------------------------------------------------------------------
// mult_simd_pipe
// LANES independent INT_SIZE x INT_SIZE multipliers behind a STAGES-deep
// valid/ready pipeline with a single global stall.
// Ports:
//   clk   : rising-edge clock
//   rst   : asynchronous active-low reset
//   bus   : mult_simd_pipe_if.slave (operands, mode, results, handshakes)
//   busy  : some pipeline stage holds a valid transaction
//   done  : one-cycle pulse after the pipeline drains to empty
// The products are formed in front of the first register stage; the remaining
// stages only carry the finished result, so the last stage drives result and
// out_valid straight from flops. STAGES must be in 1..8.
// -----------------------------------------------------------------------------
module mult_simd_pipe #(
  parameter int INT_SIZE = 16,
  parameter int LANES    = 4,
  parameter int STAGES   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_simd_pipe_if.slave      bus,
  output logic                 busy,
  output logic                 done
);

  localparam int PW = 2 * INT_SIZE;
  localparam int RW = LANES * PW;

  typedef logic [0:RW-1] res_t;

  logic              stall;
  logic              accept;
  logic              out_hs;
  res_t              prod_d;
  res_t              data_q [STAGES];
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic              done_q;

  // One lane: widen both operands to PW bits (sign- or zero-extended) and keep
  // the low PW bits of the product, which is the exact two's-complement result.
  // Low-half mode keeps only the bottom INT_SIZE bits, which do not depend on
  // signedness, so the upper half is simply zero.
  function automatic logic [PW-1:0] lane_mul(input logic [INT_SIZE-1:0] x,
                                             input logic [INT_SIZE-1:0] y,
                                             input logic [1:0]          m);
    logic [PW-1:0] ex;
    logic [PW-1:0] ey;
    logic [PW-1:0] p;
    ex = m[0] ? {{INT_SIZE{x[INT_SIZE-1]}}, x} : {{INT_SIZE{1'b0}}, x};
    ey = m[0] ? {{INT_SIZE{y[INT_SIZE-1]}}, y} : {{INT_SIZE{1'b0}}, y};
    p  = ex * ey;
    if (m[1]) p = {{INT_SIZE{1'b0}}, p[INT_SIZE-1:0]};
    return p;
  endfunction

  // Stall is global: a waiting result freezes every stage, bubbles included.
  assign stall         = vld_q[STAGES-1] && !bus.out_ready;
  assign accept        = bus.in_valid && !stall;
  assign out_hs        = vld_q[STAGES-1] && bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.result    = data_q[STAGES-1];
  assign busy          = |vld_q;
  assign done          = done_q;

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    prod_d = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i*PW +: PW] = lane_mul(bus.a[i*INT_SIZE +: INT_SIZE],
                                    bus.b[i*INT_SIZE +: INT_SIZE],
                                    bus.mode);
    end
  end

  // Valid bits after the coming edge; also used to see whether the pipe empties.
  always_comb begin
    vld_d = vld_q;
    if (!stall) begin
      vld_d[0] = accept;
      for (int s = 1; s < STAGES; s++) vld_d[s] = vld_q[s-1];
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // the pre-edge value of its predecessor and the shift order does not matter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      done_q <= 1'b0;
      // NOTE: the data stages are reset too, because result must read as zero
      // after reset; without that they could be left unreset to save area.
      for (int s = 0; s < STAGES; s++) data_q[s] <= '0;
    end else begin
      vld_q  <= vld_d;
      // Drain pulse: last result leaves, nothing enters, nothing left behind.
      done_q <= out_hs && !accept && (vld_d == '0);
      if (!stall) begin
        if (accept) data_q[0] <= prod_d;
        for (int s = 1; s < STAGES; s++) begin
          if (vld_q[s-1]) data_q[s] <= data_q[s-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_simd_pipe.sv
// -----------------------------------------------------------------------------
// tb_mult_simd_pipe
// Scoreboard bench for mult_simd_pipe (INT_SIZE=16, LANES=4, STAGES=3).
// The driver pushes the expected product when a transaction is accepted; an
// output monitor compares the head of the queue whenever out_valid is seen and
// pops it on the output handshake; a status monitor checks in_ready, busy and
// done against the queue occupancy. All sampling is one time unit before the
// rising edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_mult_simd_pipe;

  localparam int W = 16;
  localparam int L = 4;
  localparam int S = 3;

  typedef logic [0:L*W-1]   op_t;
  typedef logic [0:L*2*W-1] res_t;

  typedef struct {
    res_t res;
    int   acc_edge;
  } exp_t;

  logic clk;
  logic rst;
  logic busy;
  logic done;

  mult_simd_pipe_if #(.INT_SIZE(W), .LANES(L)) bus ();

  mult_simd_pipe #(.INT_SIZE(W), .LANES(L), .STAGES(S)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy),
    .done (done)
  );

  exp_t q[$];
  int   n_cmp     = 0;
  int   n_fail    = 0;
  int   cyc       = 0;
  int   done_cnt  = 0;
  bit   chk_lat   = 0;
  bit   head_seen = 0;
  bit   rand_on   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: per-lane integer multiply, then truncate to the width the
  // mode asks for.
  function automatic res_t model(input op_t ta, input op_t tb, input logic [1:0] tm);
    res_t r;
    r = '0;
    for (int i = 0; i < L; i++) begin
      logic [W-1:0] la;
      logic [W-1:0] lb;
      longint av, bv, p, mask;
      la   = ta[i*W +: W];
      lb   = tb[i*W +: W];
      av   = tm[0] ? longint'($signed(la)) : longint'(la);
      bv   = tm[0] ? longint'($signed(lb)) : longint'(lb);
      p    = av * bv;
      mask = (longint'(1) << (tm[1] ? W : 2*W)) - 1;
      p    = p & mask;
      r[i*2*W +: 2*W] = p[2*W-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input op_t ta, input op_t tb, input logic [1:0] tm, input res_t te);
    bit   acc;
    exp_t e;
    acc          = 0;
    bus.in_valid = 1'b1;
    bus.a        = ta;
    bus.b        = tb;
    bus.mode     = tm;
    for (int i = 0; i < 100 && !acc; i++) begin
      #4;
      if (bus.in_ready) begin
        acc        = 1;
        e.res      = te;
        e.acc_edge = cyc + 1;
        q.push_back(e);
      end
      @(negedge clk);
    end
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  // Output monitor.
  initial begin
    exp_t d;
    forever begin
      @(negedge clk);
      #4;
      if (rst && bus.out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got result %0h, required no output", bus.result);
        end else begin
          if (!head_seen) begin
            head_seen = 1;
            if (chk_lat) check("latency", 128'(cyc - q[0].acc_edge), 128'(S - 1));
          end
          check("result", bus.result, q[0].res);
          if (bus.out_ready) begin
            d         = q.pop_front();
            head_seen = 0;
          end
        end
      end
    end
  end

  // Status monitor: in_ready before the edge, busy/done after it.
  initial begin
    bit ok, s_ohs, s_ihs;
    forever begin
      @(negedge clk);
      #4;
      ok    = rst;
      s_ohs = bus.out_valid && bus.out_ready;
      s_ihs = bus.in_valid && bus.in_ready;
      if (ok) check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      @(posedge clk);
      #2;
      if (ok && rst) begin
        check("busy", busy, q.size() != 0);
        check("done", done, s_ohs && !s_ihs && q.size() == 0);
        if (done) done_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to have finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    op_t  ta, tb;
    res_t te;
    int   d0;

    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.mode      = 2'b00;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    check("reset_in_ready", bus.in_ready, 1'b1);
    check("reset_out_valid", bus.out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", bus.result, '0);

    // Single unsigned transaction with latency and drain-pulse checks.
    chk_lat = 1;
    d0 = done_cnt;
    send({16'hFFFF, 16'h0003, 16'h0000, 16'h1234},
         {16'hFFFF, 16'h0005, 16'h7777, 16'h0001}, 2'b00,
         {32'hFFFE0001, 32'h0000000F, 32'h00000000, 32'h00001234});
    drain();
    check("single_done_pulses", 128'(done_cnt - d0), 128'(1));

    // Signed full products.
    send({16'hFFFF, 16'h8000, 16'h8000, 16'h0001},
         {16'h0002, 16'h8000, 16'h7FFF, 16'hFFFF}, 2'b01,
         {32'hFFFFFFFE, 32'h40000000, 32'hC0008000, 32'hFFFFFFFF});
    drain();

    // Low half, mode 10 and 11 back to back.
    send({16'h1234, 16'hFFFF, 16'h1234, 16'hFFFF},
         {16'h0100, 16'hFFFF, 16'h0100, 16'hFFFF}, 2'b10,
         {32'h00003400, 32'h00000001, 32'h00003400, 32'h00000001});
    send({16'h1234, 16'hFFFF, 16'h1234, 16'hFFFF},
         {16'h0100, 16'hFFFF, 16'h0100, 16'hFFFF}, 2'b11,
         {32'h00003400, 32'h00000001, 32'h00003400, 32'h00000001});
    drain();

    // Streaming k*k, one per cycle; only one drain pulse at the very end.
    d0 = done_cnt;
    for (int k = 1; k <= 10; k++) begin
      logic [W-1:0]   kv;
      logic [2*W-1:0] kk;
      kv = W'(k);
      kk = 32'(k * k);
      send({kv, kv, kv, kv}, {kv, kv, kv, kv}, 2'b00, {kk, kk, kk, kk});
    end
    drain();
    check("stream_done_pulses", 128'(done_cnt - d0), 128'(1));
    chk_lat = 0;

    // Backpressure: out_ready low for 4 cycles mid-stream.
    fork
      begin
        for (int t = 0; t < 6; t++) begin
          for (int l = 0; l < L; l++) begin
            ta[l*W +: W] = rnd_op();
            tb[l*W +: W] = rnd_op();
          end
          send(ta, tb, 2'(t), model(ta, tb, 2'(t)));
        end
        bus.in_valid = 1'b0;
      end
      begin
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Reset while two transactions are in flight.
    for (int t = 0; t < 2; t++) begin
      ta = {16'h0011, 16'h0022, 16'h0033, 16'h0044};
      tb = {16'h0002, 16'h0003, 16'h0004, 16'h0005};
      send(ta, tb, 2'b00, model(ta, tb, 2'b00));
    end
    bus.in_valid = 1'b0;
    #3;
    rst = 1'b0;
    q.delete();
    head_seen = 0;
    #1;
    check("midreset_out_valid", bus.out_valid, 1'b0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_result", bus.result, '0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("post_reset_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    idle(8);
    ta = {16'h7FFF, 16'h8001, 16'hABCD, 16'h0000};
    tb = {16'h7FFF, 16'hFFFF, 16'h1111, 16'hFFFF};
    send(ta, tb, 2'b01, model(ta, tb, 2'b01));
    drain();

    // Randomized traffic with random input gaps and random backpressure.
    rand_on = 1;
    fork
      begin
        for (int t = 0; t < 250; t++) begin
          logic [1:0] tm;
          for (int l = 0; l < L; l++) begin
            ta[l*W +: W] = rnd_op();
            tb[l*W +: W] = rnd_op();
          end
          tm = 2'($urandom_range(0, 3));
          send(ta, tb, tm, model(ta, tb, tm));
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        bus.in_valid = 1'b0;
        rand_on = 0;
      end
      begin
        while (rand_on) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_simd_pipe.md
Name: mult_simd_pipe

Overview:
- Parametrised successor to the single-lane, single-cycle multiplier used by the TMVP datapath.
- Multiplies LANES independent INT_SIZE-bit operand pairs per transaction through a STAGES-deep pipeline.
- Selects signed/unsigned and full/low-half product per transaction.
- Uses valid/ready handshakes on both sides with full backpressure, plus busy/done status for the VLIW issue controller.

Parameters:
- INT_SIZE, 16, bits per operand lane
- LANES, 4, number of parallel multiplier lanes
- STAGES, 3, pipeline depth = accept-to-out_valid latency in cycles; legal range 1..8

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  upstream presents a transaction
- in_ready  output  1  block accepts the transaction this cycle
- a  input  [0:LANES*INT_SIZE-1]  operand A; lane i = bits [i*INT_SIZE +: INT_SIZE], lane 0 leftmost
- b  input  [0:LANES*INT_SIZE-1]  operand B, same packing
- mode  input  2  bit0 = signed (1) / unsigned (0); bit1 = low-half only (1) / full product (0)
- out_valid  output  1  result holds a valid transaction
- out_ready  input  1  downstream takes the result this cycle
- result  output  [0:LANES*2*INT_SIZE-1]  products; lane i = bits [i*2*INT_SIZE +: 2*INT_SIZE]
- busy  output  1  at least one pipeline stage holds valid data
- done  output  1  one-cycle pulse when the pipeline drains to empty

Behaviour:
- Reset (rst=0, asynchronous):
  - All stage valid bits, result, out_valid, done cleared to 0.
  - in_ready=1 once reset is released; busy=0.
  - Reset mid-operation discards all in-flight transactions with no partial output.
- Accept: handshake when in_valid && in_ready. a, b and mode are captured together, and mode travels with its data.
- Pipeline:
  - STAGES register stages, each with its own valid bit.
  - The multiply may be split across stages in any way, provided the result is bit-exact.
  - The last stage drives result/out_valid directly from registers.
- Stall is global: stall = out_valid && !out_ready. While stalled, every stage holds its data and valid bit.
- in_ready = !stall. It is combinational from out_ready and is not gated by in_valid.
- Bubbles are not compressed. Invalid stages advance normally when not stalled.
- Latency: accept at edge N gives out_valid=1 after edge N+STAGES-1. With STAGES=1, the result is registered on the accepting edge.
- Throughput: one transaction per cycle with out_ready held high.
- Arithmetic, per lane, independent, no cross-lane carry:
  - mode=00: unsigned full 2*INT_SIZE product.
  - mode=01: two's-complement signed full product.
  - mode=10: low INT_SIZE bits of the product, zero-extended into the upper half.
  - mode=11: same as 10. The low half is sign-independent, so upper bits are zero.
- Data hold: result is stable while out_valid && !out_ready. When out_valid=0, result retains its last value and is don't-care.
- busy: combinational OR of all stage valid bits.
- done:
  - Registered. It goes to 1 for exactly one cycle after an edge where an output handshake occurred, no accept occurred, and all stage valids are 0 after that edge.
  - Otherwise 0.
  - Simultaneous accept and output handshake suppresses done.
- Simultaneous accept and output handshake in the same cycle is legal and must not lose or duplicate data.

Test Plan:
- Single op, INT_SIZE=16, LANES=4, STAGES=3, mode=00:
  - Stimulus: a lanes = {FFFF, 0003, 0000, 1234}, b lanes = {FFFF, 0005, 7777, 0001}.
  - Required: out_valid exactly 3 edges after accept; result lanes = {FFFE0001, 0000000F, 00000000, 00001234}.
  - Required: busy high during flight; done pulses once after the handshake.
- Signed mode=01:
  - Stimulus: lanes (FFFF×0002), (8000×8000), (8000×7FFF), (0001×FFFF).
  - Required: result lanes = {FFFFFFFE, 40000000, C0008000, FFFFFFFF}.
- Low-half mode=10:
  - Stimulus: 1234×0100 and FFFF×FFFF.
  - Required: 00003400 and 00000001. mode=11 with the same stimulus gives identical results.
- Streaming:
  - Stimulus: 10 back-to-back transactions with lane value k×k, out_ready=1.
  - Required: in_ready stays 1; 10 results in order on consecutive cycles; no done pulse until after the last one.
- Backpressure:
  - Stimulus: stream 6 transactions, hold out_ready=0 for 4 cycles mid-stream.
  - Required: in_ready=0 during the stall; result stable; no loss or duplication; order preserved.
- Reset mid-flight:
  - Stimulus: accept 2 transactions, assert rst=0 asynchronously between edges.
  - Required: out_valid, busy, done, result go to 0 immediately; no stale result appears after release; a new transaction completes normally.
